// File: rtl/aes_pkg.sv
// aes_pkg: AES state type, S-box and round primitives shared by the ciphers.
// Byte k of a block (FIPS order) sits at state[3-k/4][3-k%4].
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t sub_bytes(state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = SBOX[s[c][r]];
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[3-c][3-r] = s[3-((c+r)%4)][3-r];
        return o;
    endfunction

    function automatic state_t mix_columns(state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c][3];
            a1 = s[c][2];
            a2 = s[c][1];
            a3 = s[c][0];
            o[c][3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[c][2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[c][1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[c][0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic state_t add_round_key(state_t s, state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encrypt round; final_round_i skips
// MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         final_round_i,
    output logic [127:0] state_o
);

    state_t sr;
    state_t mc;

    always_comb begin
        sr = shift_rows(sub_bytes(state_t'(state_i)));
        mc = final_round_i ? sr : mix_columns(sr);
        state_o = add_round_key(mc, state_t'(rkey_i));
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryptor, one round per clock through a
// single shared round datapath, valid/ready on both sides.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          pt,
    input  logic [128*(Nr+1)-1:0] rkey,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ct
);

    localparam int CW = $clog2(Nr + 1);
    localparam logic [CW-1:0] FIRST = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(Nr);

    fsm_e          fsm_q;
    logic [CW-1:0] cnt_q;
    logic [127:0]  st_q;
    logic [127:0]  st_d;
    logic [127:0]  ark_d;
    logic          out_valid_q;
    logic          accept;
    logic [127:0]  rks [Nr+1];

    // Word 0 of each round key lands in the block's first column.
    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        for (genvar i = 0; i < 4; i++) begin : g_w
            assign rks[r][127-32*i -: 32] = rkey[32*(4*r+i) +: 32];
        end
    end

    assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign accept = in_valid && in_ready;
    assign ark_d = add_round_key(state_t'(pt), state_t'(rks[0]));

    aes_round u_round (
        .state_i       (st_q),
        .rkey_i        (rks[cnt_q]),
        .final_round_i (cnt_q == LAST),
        .state_o       (st_d)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: ;
                ROUND: begin
                    st_q <= st_d;
                    if (cnt_q == LAST) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
            // Acceptance overrides, so DONE can hand off straight to ROUND.
            if (accept) begin
                st_q  <= ark_d;
                cnt_q <= FIRST;
                fsm_q <= ROUND;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ct = st_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: checks the iterative encryptor at Nk=4/6/8 against
// FIPS-197 vectors and a byte-level software AES model.
module tb_aes_cipher_iter;

    logic          clk;
    logic          reset_b;
    logic          in_valid;
    logic          out_ready;
    logic [127:0]  pt;
    logic [1407:0] rk4;
    logic [1663:0] rk6;
    logic [1919:0] rk8;
    logic          in_ready4, in_ready6, in_ready8;
    logic          out_valid4, out_valid6, out_valid8;
    logic [127:0]  ct4, ct6, ct8;

    int total = 0;
    int bad = 0;

    logic [7:0]    sb [256];
    logic [31:0]   ksw [60];
    logic [1919:0] rk_all;

    aes_cipher_iter #(.Nk(4)) dut4 (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid),
        .in_ready(in_ready4), .pt(pt), .rkey(rk4),
        .out_valid(out_valid4), .out_ready(out_ready), .ct(ct4)
    );

    aes_cipher_iter #(.Nk(6)) dut6 (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid),
        .in_ready(in_ready6), .pt(pt), .rkey(rk6),
        .out_valid(out_valid6), .out_ready(out_ready), .ct(ct6)
    );

    aes_cipher_iter #(.Nk(8)) dut8 (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid),
        .in_ready(in_ready8), .pt(pt), .rkey(rk8),
        .out_valid(out_valid8), .out_ready(out_ready), .ct(ct8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox_calc(logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = 8'h63;
        for (int n = 0; n < 5; n++) begin
            s ^= inv;
            inv = {inv[6:0], inv[7]};
        end
        return s;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key, input int nk);
        int nr;
        logic [31:0] t;
        logic [7:0] rc;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                ksw[i] = key[255-32*i -: 32];
            end else begin
                t = ksw[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                ksw[i] = ksw[i-nk] ^ t;
            end
        end
        rk_all = '0;
        for (int i = 0; i < 4*(nr+1); i++) rk_all[32*i +: 32] = ksw[i];
        case (nk)
            4: rk4 = rk_all[1407:0];
            6: rk6 = rk_all[1663:0];
            default: rk8 = rk_all;
        endcase
    endtask

    function automatic logic [7:0] rkb(int rd, int k);
        logic [31:0] w;
        w = ksw[4*rd + k/4];
        return w[31-8*(k%4) -: 8];
    endfunction

    function automatic logic [127:0] model_enc(logic [127:0] p, int nr);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int k = 0; k < 16; k++) b[k] = p[127-8*k -: 8] ^ rkb(0, k);
        for (int rd = 1; rd <= nr; rd++) begin
            for (int k = 0; k < 16; k++) b[k] = sb[b[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = b[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rd < nr) begin
                    b[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03)
                             ^ t[4*c+2] ^ t[4*c+3];
                    b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02)
                             ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    b[4*c+2] = t[4*c] ^ t[4*c+1]
                             ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    b[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1]
                             ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) b[4*c+r] = t[4*c+r];
                end
            end
            for (int k = 0; k < 16; k++) b[k] ^= rkb(rd, k);
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = b[k];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        reset_b = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pt = '0;
        rk4 = '0;
        rk6 = '0;
        rk8 = '0;
        #1;
        total++;
        if (out_valid4 !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid4);
        end
        total++;
        if (ct4 !== 128'h0) begin
            bad++; $display("FAIL rst_ct got=%h exp=0", ct4);
        end
        total++;
        if (in_ready4 !== 1'b1) begin
            bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready4);
        end
        total++;
        if (out_valid8 !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid8 got=%b exp=0", out_valid8);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL rst_release got=%b%b exp=10", in_ready4, out_valid4);
        end
    endtask

    task automatic test_fips();
        logic [255:0] key;
        logic [127:0] p;
        logic [127:0] m;
        logic [127:0] got4, got6, got8;
        int lat4, lat6, lat8;
        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        p = 128'h00112233445566778899aabbccddeeff;
        load_key(key, 4);
        m = model_enc(p, 10);
        total++;
        if (m !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            bad++; $display("FAIL model_c1 got=%h", m);
        end
        load_key(key, 6);
        m = model_enc(p, 12);
        total++;
        if (m !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin
            bad++; $display("FAIL model_c2 got=%h", m);
        end
        load_key(key, 8);
        m = model_enc(p, 14);
        total++;
        if (m !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            bad++; $display("FAIL model_c3 got=%h", m);
        end
        @(negedge clk);
        pt = p;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat4 = -1; lat6 = -1; lat8 = -1;
        got4 = '0; got6 = '0; got8 = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid4 && lat4 < 0) begin lat4 = n; got4 = ct4; end
            if (out_valid6 && lat6 < 0) begin lat6 = n; got6 = ct6; end
            if (out_valid8 && lat8 < 0) begin lat8 = n; got8 = ct8; end
        end
        total++;
        if (lat4 != 10) begin bad++; $display("FAIL c1_latency got=%0d exp=10", lat4); end
        total++;
        if (got4 !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            bad++; $display("FAIL c1_ct got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", got4);
        end
        total++;
        if (lat6 != 12) begin bad++; $display("FAIL c2_latency got=%0d exp=12", lat6); end
        total++;
        if (got6 !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin
            bad++; $display("FAIL c2_ct got=%h exp=dda97ca4864cdfe06eaf70a0ec0d7191", got6);
        end
        total++;
        if (lat8 != 14) begin bad++; $display("FAIL c3_latency got=%0d exp=14", lat8); end
        total++;
        if (got8 !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            bad++; $display("FAIL c3_ct got=%h exp=8ea2b7ca516745bfeafc49904b496089", got8);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        int lat;
        load_key({rand128(), 128'h0}, 4);
        @(negedge clk);
        pt = rand128();
        e = model_enc(pt, 10);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (out_valid4) begin lat = n; break; end
        end
        total++;
        if (lat != 10) begin bad++; $display("FAIL bp_latency got=%0d exp=10", lat); end
        pt = rand128();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid4 !== 1'b1) begin
                bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid4);
            end
            total++;
            if (ct4 !== e) begin
                bad++; $display("FAIL bp_ct cyc=%0d got=%h exp=%h", i, ct4, e);
            end
            total++;
            if (in_ready4 !== 1'b0) begin
                bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready4);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b%b exp=01", out_valid4, in_ready4);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exq [$];
        int accq [$];
        logic [127:0] cur, e;
        int cyc, outs, issued, last_out, a;
        logic acc;
        cyc = 0; outs = 0; issued = 0; last_out = -1;
        load_key({rand128(), 128'h0}, 4);
        pt = rand128();
        cur = model_enc(pt, 10);
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (outs < 4 && cyc < 200) begin
            @(negedge clk);
            acc = in_valid && in_ready4;
            if (out_valid4 && out_ready) begin
                e = exq.size() > 0 ? exq.pop_front() : 128'h0;
                a = accq.size() > 0 ? accq.pop_front() : -100;
                total++;
                if (ct4 !== e) begin
                    bad++; $display("FAIL b2b_ct blk=%0d got=%h exp=%h", outs, ct4, e);
                end
                total++;
                if (cyc - a != 10) begin
                    bad++; $display("FAIL b2b_latency blk=%0d got=%0d exp=10", outs, cyc - a);
                end
                if (last_out >= 0) begin
                    total++;
                    if (cyc - last_out != 11) begin
                        bad++;
                        $display("FAIL b2b_period blk=%0d got=%0d exp=11", outs, cyc - last_out);
                    end
                end
                last_out = cyc;
                outs++;
            end
            if (acc) begin
                exq.push_back(cur);
                accq.push_back(cyc + 1);
                issued++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                if (issued < 4) begin
                    pt = rand128();
                    cur = model_enc(pt, 10);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        total++;
        if (outs != 4) begin bad++; $display("FAIL b2b_timeout got=%0d exp=4", outs); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        logic [127:0] e;
        int lat;
        logic [127:0] got;
        load_key({rand128(), 128'h0}, 4);
        @(negedge clk);
        pt = rand128();
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        total++;
        if (out_valid4 !== 1'b0) begin
            bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid4);
        end
        total++;
        if (ct4 !== 128'h0) begin
            bad++; $display("FAIL midrst_ct got=%h exp=0", ct4);
        end
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready4 !== 1'b1) begin
            bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready4);
        end
        load_key({rand128(), 128'h0}, 4);
        @(negedge clk);
        pt = rand128();
        e = model_enc(pt, 10);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        got = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (out_valid4) begin lat = n; got = ct4; break; end
        end
        total++;
        if (lat != 10) begin bad++; $display("FAIL midrst_latency got=%0d exp=10", lat); end
        total++;
        if (got !== e) begin bad++; $display("FAIL midrst_ct2 got=%h exp=%h", got, e); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [127:0] exq [$];
        logic [127:0] cur, e;
        int issued, done, cyc;
        logic acc, hs;
        issued = 0; done = 0; cyc = 0;
        cur = '0;
        in_valid = 1'b0;
        while (done < 1000 && cyc < 60000) begin
            if (!in_valid && issued < 1000 && (exq.size() == 0 || out_valid4)
                && $urandom_range(0, 3) != 0) begin
                load_key({rand128(), 128'h0}, 4);
                pt = rand128();
                cur = model_enc(pt, 10);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = out_valid4 && out_ready;
            acc = in_valid && in_ready4;
            if (hs) begin
                total++;
                if (exq.size() == 0) begin
                    bad++; $display("FAIL rand_spurious got=%h exp=none", ct4);
                end else begin
                    e = exq.pop_front();
                    if (ct4 !== e) begin
                        bad++; $display("FAIL rand_ct blk=%0d got=%h exp=%h", done, ct4, e);
                    end
                end
                done++;
            end
            if (acc) begin
                exq.push_back(cur);
                issued++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        total++;
        if (done != 1000) begin bad++; $display("FAIL rand_timeout got=%0d exp=1000", done); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
